// File: rtl/multi_cycle_control.sv
// Control FSM for a multi-cycle CPU datapath: FETCH/DECODE/EXEC/MEM/WB, with a
// memory-wait timeout. Strobes qualified by mem_ready/zero are decoded combinationally.
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       ext_ctrl,
  output logic       illegal,
  output logic       mem_err,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_ANDI = 6'h05;
  localparam logic [5:0] OP_ORI  = 6'h06;
  localparam logic [5:0] OP_LW   = 6'h07;
  localparam logic [5:0] OP_SW   = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_BNE  = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h0B;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    opc_q;
  logic          ext_q;

  logic is_legal, is_branch, br_taken, wait_st, timeout;

  always_comb begin
    is_legal = 1'b0;
    case (opc_q)
      OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW,
      OP_SW, OP_BEQ, OP_BNE, OP_J: is_legal = 1'b1;
      default:                     is_legal = 1'b0;
    endcase
  end

  assign is_branch = (opc_q == OP_BEQ) || (opc_q == OP_BNE);
  assign br_taken  = ((opc_q == OP_BEQ) && zero) || ((opc_q == OP_BNE) && !zero);
  assign wait_st   = (state_q == FETCH) || (state_q == MEM);
  // A ready arriving on the timeout cycle completes the access instead.
  assign timeout   = wait_st && !mem_ready && (cnt_q == TMO);

  // Every state other than FETCH/MEM holds cnt_q at zero, so entry always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      opc_q   <= '0;
      ext_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
            opc_q   <= opcode;
            ext_q   <= !((opcode == OP_ANDI) || (opcode == OP_ORI));
            cnt_q   <= '0;
          end else if (timeout) begin
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        DECODE: begin
          cnt_q   <= '0;
          state_q <= (!is_legal || opc_q == OP_J) ? FETCH : EXEC;
        end
        EXEC: begin
          cnt_q <= '0;
          if (is_branch)                               state_q <= FETCH;
          else if (opc_q == OP_LW || opc_q == OP_SW)   state_q <= MEM;
          else                                         state_q <= WB;
        end
        MEM: begin
          if (mem_ready) begin
            state_q <= (opc_q == OP_LW) ? WB : FETCH;
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q <= FETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        WB: begin
          state_q <= FETCH;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= FETCH;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    pc_src    = 2'd0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        mem_err   = timeout;
      end
      DECODE: begin
        illegal = !is_legal;
        if (opc_q == OP_J) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
      end
      EXEC: begin
        case (opc_q)
          OP_R:                   alu_op = 2'd2;
          OP_ADDI, OP_LW, OP_SW:  alu_src_b = 2'd2;
          OP_ANDI, OP_ORI: begin
            alu_src_b = 2'd2;
            alu_op    = 2'd3;
          end
          OP_BEQ, OP_BNE: begin
            alu_op   = 2'd1;
            pc_src   = 2'd1;
            pc_write = br_taken;
          end
          default: ;
        endcase
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = (opc_q == OP_LW);
        mem_write = (opc_q == OP_SW);
        mem_err   = timeout;
      end
      WB: begin
        reg_write = 1'b1;
        wb_sel    = (opc_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign ext_ctrl = ext_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control. Each cycle's full control word
// {state, mr,mw,iord,irw,pcw,rw,wbs,ext,ill,err, alu_src_b, alu_op, pc_src} is hand-derived.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] opcode;
  logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic       wb_sel, ext_ctrl, illegal, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [2:0] state;
  logic [18:0] ctl;
  int checks = 0;
  int errors = 0;

  multi_cycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .wb_sel(wb_sel), .ext_ctrl(ext_ctrl),
    .illegal(illegal), .mem_err(mem_err), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state)
  );

  always #5 clk = ~clk;

  assign ctl = {state, mem_read, mem_write, iord, ir_write, pc_write, reg_write,
                wb_sel, ext_ctrl, illegal, mem_err, alu_src_b, alu_op, pc_src};

  // Tasks start at a falling edge: inputs set, outputs sampled 1ns later.
  task automatic test_reset();
    logic [18:0] e;
    e = {3'd0, 10'b1000000000, 2'd1, 2'd0, 2'd0};
    mem_ready = 1'b0;
    #1; checks++;
    if (ctl !== e) begin errors++; $display("FAIL reset got %b exp %b", ctl, e); end
    @(negedge clk);
  endtask

  task automatic test_addi();
    logic [18:0] e [4];
    e = '{{3'd0, 10'b1001100000, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd2, 2'd0, 2'd0},
          {3'd4, 10'b0000010100, 2'd0, 2'd0, 2'd0}};
    opcode = 6'h04; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL addi cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_ori_lw();
    logic [18:0] e [9];
    e = '{{3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000000, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000000, 2'd2, 2'd3, 2'd0},
          {3'd4, 10'b0000010000, 2'd0, 2'd0, 2'd0},
          {3'd0, 10'b1001100000, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd2, 2'd0, 2'd0},
          {3'd3, 10'b1010000100, 2'd0, 2'd0, 2'd0},
          {3'd4, 10'b0000011100, 2'd0, 2'd0, 2'd0}};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      opcode = (i < 4) ? 6'h06 : 6'h07;
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL ori_lw cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [18:0] e [6];
    e = '{{3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000100100, 2'd0, 2'd1, 2'd1},
          {3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd0, 2'd1, 2'd1}};
    mem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = (i < 3) ? 6'h09 : 6'h0A;
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL branch cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  // Last MEM cycle has mem_ready on the same cycle the counter hits the limit.
  task automatic test_sw_wait();
    logic [18:0] e [7];
    logic [6:0]  rdy;
    e = '{{3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd2, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0}};
    rdy = 7'b1000111;
    opcode = 6'h08;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL sw_wait cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    logic [18:0] e;
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = (i == 3 || i == 7) ? {3'd0, 10'b1000000101, 2'd1, 2'd0, 2'd0}
                             : {3'd0, 10'b1000000100, 2'd1, 2'd0, 2'd0};
      #1; checks++;
      if (ctl !== e) begin errors++; $display("FAIL fetch_timeout cyc%0d got %b exp %b", i, ctl, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_timeout();
    logic [18:0] e [8];
    logic [7:0]  rdy;
    e = '{{3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd2, 2'd0, 2'd0},
          {3'd3, 10'b1010000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b1010000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b1010000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b1010000101, 2'd0, 2'd0, 2'd0},
          {3'd0, 10'b1000000100, 2'd1, 2'd0, 2'd0}};
    rdy = 8'b00000111;
    opcode = 6'h07;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL mem_timeout cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_decode_ops();
    logic [18:0] e [12];
    logic [5:0]  op [12];
    e = '{{3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000110, 2'd0, 2'd0, 2'd0},
          {3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000100100, 2'd0, 2'd0, 2'd2},
          {3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd0, 2'd2, 2'd0},
          {3'd4, 10'b0000010100, 2'd0, 2'd0, 2'd0},
          {3'd0, 10'b1001100100, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000000, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000000, 2'd2, 2'd3, 2'd0},
          {3'd4, 10'b0000010000, 2'd0, 2'd0, 2'd0}};
    op = '{6'h3F, 6'h3F, 6'h0B, 6'h0B, 6'h00, 6'h00, 6'h00, 6'h00,
           6'h05, 6'h05, 6'h05, 6'h05};
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      opcode = op[i];
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL decode_ops cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mem();
    logic [18:0] e [7];
    e = '{{3'd0, 10'b1001100000, 2'd1, 2'd0, 2'd0},
          {3'd1, 10'b0000000100, 2'd0, 2'd0, 2'd0},
          {3'd2, 10'b0000000100, 2'd2, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0},
          {3'd3, 10'b0110000100, 2'd0, 2'd0, 2'd0},
          {3'd0, 10'b1000000000, 2'd1, 2'd0, 2'd0},
          {3'd0, 10'b1000000000, 2'd1, 2'd0, 2'd0}};
    opcode = 6'h08;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i < 3);
      rst = (i == 4 || i == 5);
      #1; checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL reset_mem cyc%0d got %b exp %b", i, ctl, e[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_addi();
    test_ori_lw();
    test_branch();
    test_sw_wait();
    test_fetch_timeout();
    test_mem_timeout();
    test_decode_ops();
    test_reset_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
